// File: rtl/ac97_playbuf_pkg.sv
// Shared AC97 playback definitions: sample width, playback state encodings
// and a small saturating-counter helper.
package ac97_playbuf_pkg;

  localparam int SAMPLE_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } play_state_e;

  // Increment a 16-bit counter, sticking at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/ac97_playbuf_if.sv
// DMA-side write handshake plus framer-side playback signals of the
// AC97 playback buffer. master = DMA/framer side, slave = buffer.
interface ac97_playbuf_if #(
  parameter int DEPTH_LOG2 = 4
);
  import ac97_playbuf_pkg::*;

  logic                  wr_stb;
  logic                  wr_ack;
  logic [SAMPLE_W-1:0]   wr_left;
  logic [SAMPLE_W-1:0]   wr_right;
  logic                  en;
  logic                  next_frame;
  logic                  flush;
  logic                  pcmleft_valid;
  logic [SAMPLE_W-1:0]   pcmleft;
  logic                  pcmright_valid;
  logic [SAMPLE_W-1:0]   pcmright;
  logic [DEPTH_LOG2:0]   level;
  logic                  low_water;
  logic [15:0]           underrun_count;
  logic                  underrun_irq;

  modport master (
    output wr_stb, wr_left, wr_right, en, next_frame, flush,
    input  wr_ack, pcmleft_valid, pcmleft, pcmright_valid, pcmright,
           level, low_water, underrun_count, underrun_irq
  );

  modport slave (
    input  wr_stb, wr_left, wr_right, en, next_frame, flush,
    output wr_ack, pcmleft_valid, pcmleft, pcmright_valid, pcmright,
           level, low_water, underrun_count, underrun_irq
  );

endinterface

// File: rtl/ac97_playbuf_ram.sv
// Stereo sample storage: synchronous write, asynchronous read. A written
// word is only visible through the read port after the writing edge.
module ac97_playbuf_ram #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 40
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  import ac97_playbuf_pkg::*;

  logic [WIDTH-1:0] mem_r [2**DEPTH_LOG2];

  // Write port: store the offered word on the accepting edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ac97_playbuf.sv
// AC97 playback buffer: FIFO between the DMA engine and the frame builder.
// Playback waits in PRIME until enough samples are buffered, then pops one
// stereo entry per frame boundary; an empty FIFO at a frame boundary is an
// underrun (silent frame, counter bump, interrupt pulse).
module ac97_playbuf #(
  parameter int DEPTH_LOG2  = 4,
  parameter int PRIME_LEVEL = 4
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  ac97_playbuf_if.slave  bus
);
  import ac97_playbuf_pkg::*;

  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam int PTR_W = DEPTH_LOG2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME_LEVEL);

  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [LVL_W-1:0]      level_r;
  logic [LVL_W-1:0]      level_next_s;
  logic                  low_water_r;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  wr_ack_s;
  logic [2*SAMPLE_W-1:0] rd_data_s;

  play_state_e           state_r;
  logic                  pcmleft_valid_r;
  logic                  pcmright_valid_r;
  logic [SAMPLE_W-1:0]   pcmleft_r;
  logic [SAMPLE_W-1:0]   pcmright_r;
  logic [15:0]           underrun_count_r;
  logic                  underrun_irq_r;

  ac97_playbuf_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (2 * SAMPLE_W)
  ) u_ram (
    .clk   (sys_clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata ({bus.wr_left, bus.wr_right}),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  // Push/pop decode and next fill level; full comes from the registered
  // level only, so a same-cycle pop never frees a slot for a push.
  always_comb begin
    full_s   = (level_r == FULL_LVL);
    push_s   = bus.wr_stb & ~full_s & ~bus.flush;
    pop_s    = (state_r == ST_RUN) & bus.en & bus.next_frame &
               (level_r != {LVL_W{1'b0}}) & ~bus.flush;
    wr_ack_s = push_s & sys_rst_n;
    level_next_s = level_r;
    if (bus.flush) begin
      level_next_s = {LVL_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   level_next_s = level_r + LVL_W'(1);
        2'b01:   level_next_s = level_r - LVL_W'(1);
        default: level_next_s = level_r;
      endcase
    end
  end

  // Pointer, level and low-water registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      low_water_r <= 1'b1;
    end else begin
      level_r     <= level_next_s;
      low_water_r <= (level_next_s < PRIME_LVL);
      if (bus.flush) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
      end
    end
  end

  // Playback FSM with registered slot outputs and underrun bookkeeping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r          <= ST_IDLE;
      pcmleft_valid_r  <= 1'b0;
      pcmright_valid_r <= 1'b0;
      pcmleft_r        <= {SAMPLE_W{1'b0}};
      pcmright_r       <= {SAMPLE_W{1'b0}};
      underrun_count_r <= 16'd0;
      underrun_irq_r   <= 1'b0;
    end else begin
      underrun_irq_r <= 1'b0;
      if (bus.flush || !bus.en) begin
        // Flush or disable: silence the slots; counter is kept.
        state_r          <= (bus.flush && bus.en) ? ST_PRIME : ST_IDLE;
        pcmleft_valid_r  <= 1'b0;
        pcmright_valid_r <= 1'b0;
        pcmleft_r        <= {SAMPLE_W{1'b0}};
        pcmright_r       <= {SAMPLE_W{1'b0}};
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_PRIME;
          end
          ST_PRIME: begin
            if (bus.next_frame) begin
              pcmleft_valid_r  <= 1'b0;
              pcmright_valid_r <= 1'b0;
              pcmleft_r        <= {SAMPLE_W{1'b0}};
              pcmright_r       <= {SAMPLE_W{1'b0}};
            end
            if (level_r >= PRIME_LVL) begin
              state_r <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (bus.next_frame) begin
              if (level_r != {LVL_W{1'b0}}) begin
                pcmleft_valid_r  <= 1'b1;
                pcmright_valid_r <= 1'b1;
                pcmleft_r        <= rd_data_s[2*SAMPLE_W-1:SAMPLE_W];
                pcmright_r       <= rd_data_s[SAMPLE_W-1:0];
              end else begin
                pcmleft_valid_r  <= 1'b0;
                pcmright_valid_r <= 1'b0;
                pcmleft_r        <= {SAMPLE_W{1'b0}};
                pcmright_r       <= {SAMPLE_W{1'b0}};
                underrun_count_r <= sat_inc16(underrun_count_r);
                underrun_irq_r   <= 1'b1;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.wr_ack         = wr_ack_s;
  assign bus.level          = level_r;
  assign bus.low_water      = low_water_r;
  assign bus.pcmleft_valid  = pcmleft_valid_r;
  assign bus.pcmright_valid = pcmright_valid_r;
  assign bus.pcmleft        = pcmleft_r;
  assign bus.pcmright       = pcmright_r;
  assign bus.underrun_count = underrun_count_r;
  assign bus.underrun_irq   = underrun_irq_r;

endmodule

// File: tb/tb_ac97_playbuf.sv
// Self-checking bench for ac97_playbuf: directed scenarios plus random
// traffic, compared every cycle against a queue-based playback model.
module tb_ac97_playbuf;

  localparam int DEPTH = 16;
  localparam int PRIME = 4;

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN   = 2;

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [39:0] q[$];
  int          m_st;
  logic        m_v;
  logic [19:0] m_l;
  logic [19:0] m_r;
  logic [15:0] m_cnt;
  logic        m_irq;

  ac97_playbuf_if #(.DEPTH_LOG2(4)) bus ();

  ac97_playbuf #(.DEPTH_LOG2(4), .PRIME_LEVEL(PRIME)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_st  = M_IDLE;
    m_v   = 1'b0;
    m_l   = 20'd0;
    m_r   = 20'd0;
    m_cnt = 16'd0;
    m_irq = 1'b0;
  endtask

  task automatic model_step(input logic stb, input logic [19:0] l, input logic [19:0] r,
                            input logic e, input logic nf, input logic fl);
    logic        acc;
    int          lvl0;
    logic [39:0] hd;
    acc   = stb && (q.size() < DEPTH) && !fl;
    lvl0  = q.size();
    m_irq = 1'b0;
    if (fl) begin
      q.delete();
      m_st = e ? M_PRIME : M_IDLE;
      m_v = 1'b0; m_l = 20'd0; m_r = 20'd0;
    end else begin
      if (!e) begin
        m_st = M_IDLE;
        m_v = 1'b0; m_l = 20'd0; m_r = 20'd0;
      end else if (m_st == M_IDLE) begin
        m_st = M_PRIME;
      end else if (m_st == M_PRIME) begin
        if (nf) begin
          m_v = 1'b0; m_l = 20'd0; m_r = 20'd0;
        end
        if (lvl0 >= PRIME) m_st = M_RUN;
      end else if (nf) begin
        if (lvl0 > 0) begin
          hd  = q.pop_front();
          m_v = 1'b1;
          m_l = hd[39:20];
          m_r = hd[19:0];
        end else begin
          m_v = 1'b0; m_l = 20'd0; m_r = 20'd0;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          m_irq = 1'b1;
        end
      end
      if (acc) q.push_back({l, r});
    end
  endtask

  task automatic check_outputs();
    check_eq("level",     bus.level,          q.size());
    check_eq("low_water", bus.low_water,      (q.size() < PRIME));
    check_eq("lvalid",    bus.pcmleft_valid,  m_v);
    check_eq("rvalid",    bus.pcmright_valid, m_v);
    check_eq("pcmleft",   bus.pcmleft,        m_l);
    check_eq("pcmright",  bus.pcmright,       m_r);
    check_eq("irq",       bus.underrun_irq,   m_irq);
    check_eq("count",     bus.underrun_count, m_cnt);
  endtask

  // One clock: drive at negedge, check wr_ack, step model at posedge, check.
  task automatic cycle(input logic stb, input logic [19:0] l, input logic [19:0] r,
                       input logic e, input logic nf, input logic fl);
    @(negedge clk);
    bus.wr_stb     = stb;
    bus.wr_left    = l;
    bus.wr_right   = r;
    bus.en         = e;
    bus.next_frame = nf;
    bus.flush      = fl;
    #1;
    check_eq("wr_ack", bus.wr_ack, (stb && (q.size() < DEPTH) && !fl));
    @(posedge clk);
    model_step(stb, l, r, e, nf, fl);
    #1;
    check_outputs();
  endtask

  task automatic push(input logic [19:0] l, input logic [19:0] r);
    cycle(1'b1, l, r, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic frame();
    cycle(1'b0, 20'd0, 20'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 20'd0, 20'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset values, with wr_stb offered during reset
    model_reset();
    rst_n          = 1'b0;
    bus.wr_stb     = 1'b1;
    bus.wr_left    = 20'h12345;
    bus.wr_right   = 20'h54321;
    bus.en         = 1'b0;
    bus.next_frame = 1'b0;
    bus.flush      = 1'b0;
    #13;
    check_eq("rst_wr_ack", bus.wr_ack, 1'b0);
    check_outputs();
    @(negedge clk);
    bus.wr_stb = 1'b0;
    rst_n      = 1'b1;

    // Prime: 3 pushes, two frames silent, 4th push enters RUN, first pop
    push(20'h00A01, 20'h00B01);
    push(20'h00A02, 20'h00B02);
    push(20'h00A03, 20'h00B03);
    frame();
    frame();
    check_eq("prime_level3", bus.level, 64'd3);
    check_eq("prime_v0", bus.pcmleft_valid, 1'b0);
    push(20'h00A04, 20'h00B04);
    idle();
    frame();
    check_eq("run_s0_l", bus.pcmleft, 64'h00A01);
    check_eq("run_s0_r", bus.pcmright, 64'h00B01);
    check_eq("run_s0_v", bus.pcmright_valid, 1'b1);
    check_eq("run_level3", bus.level, 64'd3);

    // Underrun: drain, then frame on empty FIFO
    repeat (3) frame();
    frame();
    check_eq("ur_irq", bus.underrun_irq, 1'b1);
    check_eq("ur_cnt1", bus.underrun_count, 64'd1);
    idle();
    check_eq("ur_irq_once", bus.underrun_irq, 1'b0);

    // Simultaneous push+pop at level 5, then push+underrun at level 0
    for (int i = 0; i < 5; i++) push(20'(i + 16'h100), 20'(i + 16'h200));
    cycle(1'b1, 20'h00777, 20'h00888, 1'b1, 1'b1, 1'b0);
    check_eq("sim_level5", bus.level, 64'd5);
    repeat (5) frame();
    cycle(1'b1, 20'h00999, 20'h00AAA, 1'b1, 1'b1, 1'b0);
    check_eq("sim_ur_level1", bus.level, 64'd1);
    check_eq("sim_ur_irq", bus.underrun_irq, 1'b1);

    // Full and wrap: 16 pushes, 17th refused, then mixed traffic
    cycle(1'b0, 20'd0, 20'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) push(20'(i), 20'(i));
    check_eq("full_level16", bus.level, 64'd16);
    push(20'h00011, 20'h00011);
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom), 20'($urandom), 20'($urandom), 1'b1, 1'($urandom), 1'b0);

    // Flush at level 9 during a frame boundary
    cycle(1'b0, 20'd0, 20'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) push(20'($urandom), 20'($urandom));
    begin
      logic [15:0] cnt_before;
      cnt_before = bus.underrun_count;
      cycle(1'b0, 20'd0, 20'd0, 1'b1, 1'b1, 1'b1);
      check_eq("flush_level0", bus.level, 64'd0);
      check_eq("flush_v0", bus.pcmleft_valid, 1'b0);
      check_eq("flush_cnt", bus.underrun_count, cnt_before);
    end
    // Still PRIME: a frame with 3 entries is silent
    for (int i = 0; i < 3; i++) push(20'h00055, 20'h00066);
    frame();
    check_eq("flush_prime_v0", bus.pcmleft_valid, 1'b0);
    check_eq("flush_prime_lvl", bus.level, 64'd3);

    // Random traffic including enable drops and rare flushes
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), 20'($urandom), 20'($urandom),
            ($urandom_range(0, 15) != 0), 1'($urandom),
            ($urandom_range(0, 40) == 0));

    // Mid-RUN asynchronous reset
    cycle(1'b0, 20'd0, 20'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) push(20'h00C00 + 20'(i), 20'h00D00 + 20'(i));
    idle();
    frame();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst_state_v", bus.pcmleft_valid, 1'b0);
    check_eq("mid_rst_wr_ack", bus.wr_ack, 1'b0);
    check_outputs();
    @(negedge clk);
    bus.en = 1'b0;
    rst_n  = 1'b1;
    idle();

    // Saturation: prime, then continuous frame boundaries on empty FIFO
    for (int i = 0; i < 4; i++) push(20'h00E00 + 20'(i), 20'h00F00 + 20'(i));
    idle();
    for (int i = 0; i < 65545; i++) frame();
    check_eq("sat_count", bus.underrun_count, 64'hFFFF);
    frame();
    check_eq("sat_hold", bus.underrun_count, 64'hFFFF);
    check_eq("sat_irq", bus.underrun_irq, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
